// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } state_e;

  // sll $0,$0,0
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Word index of a byte address relative to the base; wraps for addresses below base.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] diff;
    diff = addr - base;
    return {2'b00, diff[31:2]};
  endfunction

endpackage

// File: rtl/imem_loadable_if.sv
// Fetch and boot-load bus of the instruction memory.
interface imem_loadable_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_ready;
  logic              inst_valid;
  logic [DATA_W-1:0] instruction;
  logic              inst_fault;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   load_count;

  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
    input  fetch_ready, inst_valid, instruction, inst_fault, load_ready, load_done, load_count
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
    output fetch_ready, inst_valid, instruction, inst_fault, load_ready, load_done, load_count
  );
endinterface

// File: rtl/imem_array.sv
// Single-port synchronous RAM with write priority and a registered read that
// holds its value when no read is issued.
module imem_array #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write or registered read on the shared port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: post-reset NOP clear sweep, boot-load stream,
// 1-cycle fetch port with alignment/range fault.
// Optional macro INST_PARITY_EN adds a per-word even parity bit and sticky parity_err.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int          DEPTH     = 512,
  parameter int          ADDR_W    = $clog2(DEPTH),
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = DEFAULT_NOP_WORD
) (
  input  logic           clk,
  input  logic           reset_n,
  imem_loadable_if.slave bus,
  output logic           parity_err
);

`ifdef INST_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] w);
    return {^w, w};
  endfunction
`else
  localparam int MEM_W = DATA_W;
  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] w);
    return w;
  endfunction
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] NOP_D    = NOP_WORD[DATA_W-1:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   load_count_q;
  logic              load_done_q;
  logic              inst_valid_q;
  logic              nop_sel_q;
  logic [31:0]       idx;
  logic              fetch_acc, fetch_bad, load_exit, par_bad;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [MEM_W-1:0]  ram_wdata, ram_rdata;

  assign idx       = word_index(bus.fetch_addr, BASE_ADDR);
  assign fetch_acc = (state_q == IDLE) && bus.fetch_req;
  assign fetch_bad = (bus.fetch_addr[1:0] != 2'b00) || (idx >= 32'(DEPTH));
  assign load_exit = (state_q == LOAD) && bus.load_valid &&
                     (bus.load_last || (ptr_q == LAST_IDX));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CLEAR;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (ptr_q == LAST_IDX) state_d = IDLE;
      IDLE:    if (bus.load_start) state_d = LOAD;
      LOAD:    if (load_exit) state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // RAM port steering: clear sweep, load writes, or fetch reads.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = ptr_q;
    ram_wdata = encode(NOP_D);
    case (state_q)
      CLEAR: ram_we = 1'b1;
      LOAD: begin
        ram_we    = bus.load_valid;
        ram_wdata = encode(bus.load_data);
      end
      IDLE: begin
        ram_re   = fetch_acc && !fetch_bad;
        ram_addr = idx[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  // Pointer, load counter and fetch response flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      load_count_q <= '0;
      load_done_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      nop_sel_q    <= 1'b1;
    end else begin
      load_done_q  <= load_exit;
      inst_valid_q <= fetch_acc;
      if (fetch_acc) nop_sel_q <= fetch_bad;
      case (state_q)
        CLEAR: ptr_q <= (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
        IDLE: begin
          if (bus.load_start) begin
            ptr_q        <= '0;
            load_count_q <= '0;
          end
        end
        LOAD: begin
          if (bus.load_valid) begin
            ptr_q        <= ptr_q + 1'b1;
            load_count_q <= load_count_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .WIDTH (MEM_W)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

`ifdef INST_PARITY_EN
  logic parity_err_q;
  // A word read from the array is bad when its stored parity no longer matches.
  assign par_bad = !nop_sel_q && (^ram_rdata);

  // Sticky parity error, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   parity_err_q <= 1'b0;
    else if (inst_valid_q && par_bad) parity_err_q <= 1'b1;
  end
  assign parity_err = parity_err_q || (inst_valid_q && par_bad);
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign bus.fetch_ready = (state_q == IDLE);
  assign bus.load_ready  = (state_q == LOAD);
  assign bus.load_done   = load_done_q;
  assign bus.load_count  = load_count_q;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.inst_fault  = inst_valid_q && (nop_sel_q || par_bad);
  assign bus.instruction = (nop_sel_q || par_bad) ? NOP_D : ram_rdata[DATA_W-1:0];

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised successor to the fixed-content instruction ROM of the MIPS pipeline.
- Synchronous instruction memory with a fetch port (1-cycle latency), a boot-load port that streams a program in, and a post-reset clear sweep that fills storage with NOP.
- Sits between the IF stage and the external program loader (UART/testbench). Replaces hard-coded initial contents.

Parameters:
- DEPTH, 512, number of 32-bit instruction words.
- ADDR_W, $clog2(DEPTH), word-index width.
- DATA_W, 32, instruction width.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- NOP_WORD, 32'h0000_0000, fill/fault word (sll $0,$0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request, sampled when fetch_ready=1.
- fetch_addr  in  32  byte address (PC).
- fetch_ready  out  1  array can accept a fetch this cycle.
- inst_valid  out  1  instruction/inst_fault valid this cycle.
- instruction  out  DATA_W  fetched word.
- inst_fault  out  1  misaligned, out-of-range or parity fault on this fetch.
- load_start  in  1  begin program load (IDLE only).
- load_valid  in  1  load_data valid.
- load_data  in  DATA_W  word to write.
- load_last  in  1  final word of program, qualified by load_valid.
- load_ready  out  1  load word accepted this cycle.
- load_done  out  1  one-cycle pulse when load completes.
- load_count  out  ADDR_W+1  words written by last/current load.
- parity_err  out  1  sticky parity error (INST_PARITY_EN only).

Behaviour:
- Reset (async, reset_n=0):
  - State goes to CLEAR and the clear pointer goes to 0.
  - All outputs are 0 except instruction=NOP_WORD.
  - Memory contents are not reset directly; the CLEAR sweep rewrites them.
- States:
  - CLEAR: writes NOP_WORD to mem[ptr] each cycle, ptr++. After writing DEPTH-1 (DEPTH cycles after reset release), goes to IDLE. fetch_ready=0 and load_ready=0 throughout.
  - IDLE: fetch_ready=1, load_ready=0. load_start=1 goes to LOAD, clears the load pointer and clears load_count.
  - LOAD: fetch_ready=0, load_ready=1.
    - Each cycle with load_valid=1 writes mem[ptr]=load_data, then ptr++ and load_count++.
    - Exit to IDLE (load_done=1 for that next cycle) when load_valid and (load_last or ptr==DEPTH-1).
    - Words beyond DEPTH are never written.
    - load_start is ignored while in LOAD.
- Fetch (IDLE, fetch_req=1):
  - idx=(fetch_addr-BASE_ADDR)>>2, computed in 32 bits.
  - Next cycle: inst_valid=1, instruction=mem[idx].
  - Fault if fetch_addr[1:0]!=0 or (fetch_addr-BASE_ADDR)>>2 ≥ DEPTH. This includes addresses below BASE_ADDR, which wrap to a large value. On fault: instruction=NOP_WORD, inst_fault=1.
  - Back-to-back fetches every cycle are supported (throughput 1/cycle).
- No fetch accepted: inst_valid=0, inst_fault=0, instruction holds its last value.
- Simultaneous fetch_req and load_start in IDLE: the fetch is served with normal timing and the state moves to LOAD.
- fetch_req while fetch_ready=0: dropped, no response. The requester must retry.
- Reset mid-LOAD or mid-CLEAR: aborts immediately, restarts CLEAR, and load_count=0.
- load_count holds its value after load_done until the next load_start or reset.

Optional Feature:
- INST_PARITY_EN defined:
  - Storage is DATA_W+1 bits; the extra bit holds even parity (XOR of word), written on CLEAR and LOAD.
  - On fetch, a parity mismatch forces inst_fault=1 and instruction=NOP_WORD, and sets parity_err.
  - parity_err is sticky until reset.
- INST_PARITY_EN undefined: no parity bit, parity_err tied 0.

Decomposition:
- Package imem_pkg:
  - state enum {CLEAR, IDLE, LOAD}.
  - NOP_WORD default.
  - helper function word_index(addr, base).
- One sub-module, imem_array: single-port synchronous RAM (DEPTH x DATA_W[+1]) with write enable and registered read. imem_loadable holds the FSM, counters, fault logic and port muxing.

Test Plan:
- Reset release → fetch_ready stays 0 for exactly 512 cycles. Then fetch 0x0, 0x7FC → instruction=0x00000000, inst_fault=0.
- load_start, stream 19 words (first 0x20040005, last load_last=1 with 0x03E00008) → load_done pulse one cycle after last word, load_count=19. Fetch 0x0 → 0x20040005; fetch 0x48 → 0x03E00008; fetch 0x4C → 0x00000000.
- Fetch 0x0000_0002 → inst_fault=1, instruction=0. Fetch 0x800 (DEPTH=512) → inst_fault=1.
- Load 600 words without load_last → exits after 512 writes, load_count=512, load_ready=0 for words 513+.
- Assert reset_n=0 after 5 load words → outputs 0 immediately. After release, a full CLEAR runs and fetch 0x0 returns 0.
- INST_PARITY_EN: load 0x12345678, force-flip stored bit 0 → fetch gives inst_fault=1, parity_err=1, and parity_err stays 1 on a clean fetch after.
